kernel_control: RTL and testbench

- Line-buffer and window generator feeding a 3x3 image kernel in the color-detect pipeline.
- Accepts a raster pixel stream and stores lines in four rotating line buffers.
- Once three full lines are held, emits one 3-pixel-wide slice per kernel row (top, middle, bottom) per cycle, forming a 3x3 window.
- Throttles upstream with a request signal.

---
 rtl/kcontrol_pkg.sv | 21 ++
 rtl/kernel_line_buffer.sv | 30 +++
 rtl/kernel_control.sv | 205 ++++++++++++++++++++
 tb/tb_kernel_control.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kcontrol_pkg.sv
`default_nettype none
// ============================================================================
// kcontrol_pkg : shared constants for the kernel_control window generator
// Revision     : 1.0
// ============================================================================
package kcontrol_pkg;

    localparam int NUM_BUFS  = 4;
    localparam int BUF_IDX_W = $clog2(NUM_BUFS);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    // Slice layout: column c sits in the low field, c+1 next, c+2 on top.
    function automatic int slice_lsb(input int col_offset, input int data_width);
        return col_offset * data_width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/kernel_line_buffer.sv
`default_nettype none
// ============================================================================
// kernel_line_buffer : one-line simple dual-port RAM, registered read
// Revision           : 1.0
// ============================================================================
module kernel_line_buffer #(
    parameter  int DEPTH      = 640,
    parameter  int DATA_WIDTH = 16,
    localparam int ADDR_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // No reset on the array or read register so the block maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule
`default_nettype wire

// File: rtl/kernel_control.sv
`default_nettype none
// ============================================================================
// kernel_control : four-line rotating buffer producing 3x3 kernel windows
// Revision       : 1.0
// ============================================================================
module kernel_control
    import kcontrol_pkg::*;
#(
    parameter int LINE_LENGTH = 640,
    parameter int LINE_COUNT  = 480,
    parameter int DATA_WIDTH  = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rstn,
    input  logic [DATA_WIDTH-1:0]   i_data,
    input  logic                    i_valid,
    output logic                    o_req,
    output logic [3*DATA_WIDTH-1:0] o_r0_data,
    output logic [3*DATA_WIDTH-1:0] o_r1_data,
    output logic [3*DATA_WIDTH-1:0] o_r2_data,
    output logic                    o_valid
);

    localparam int COL_W  = $clog2(LINE_LENGTH);
    localparam int LINE_W = $clog2(LINE_COUNT + 1);
    localparam int F0     = slice_lsb(0, DATA_WIDTH);
    localparam int F1     = slice_lsb(1, DATA_WIDTH);
    localparam int F2     = slice_lsb(2, DATA_WIDTH);

    localparam logic [COL_W-1:0]  LAST_COL    = COL_W'(LINE_LENGTH - 1);
    localparam logic [LINE_W-1:0] FRAME_LINES = LINE_W'(LINE_COUNT);
    localparam logic [LINE_W-1:0] FRAME_ROWS  = LINE_W'(LINE_COUNT - 2);

    logic [COL_W-1:0]        wcol;
    logic [COL_W-1:0]        rcol;
    logic [BUF_IDX_W-1:0]    wsel;
    logic [BUF_IDX_W-1:0]    rsel;
    logic [BUF_IDX_W-1:0]    pend_sel;
    logic [LINE_W-1:0]       wline;
    logic [LINE_W-1:0]       rrow;
    logic [2:0]              filled;
    logic                    active;
    logic [1:0]              state;
    logic                    pend_valid;
    logic                    pend_first;
    logic [1:0]              shift_cnt;
    logic                    win_valid;
    logic [3*DATA_WIDTH-1:0] win0;
    logic [3*DATA_WIDTH-1:0] win1;
    logic [3*DATA_WIDTH-1:0] win2;
    logic [DATA_WIDTH-1:0]   buf_rd [NUM_BUFS];
    logic [DATA_WIDTH-1:0]   px_top;
    logic [DATA_WIDTH-1:0]   px_mid;
    logic [DATA_WIDTH-1:0]   px_bot;
    logic                    wr_fire;
    logic                    wr_line_done;
    logic                    rd_issue;
    logic                    rd_release;
    logic                    frame_done;

    // active holds o_req low through the reset cycle itself.
    assign o_req        = active && (filled < 3'd4) && (wline < FRAME_LINES);
    assign wr_fire      = i_valid && o_req;
    assign wr_line_done = wr_fire && (wcol == LAST_COL);
    assign rd_issue     = (state == ST_LOAD);
    assign rd_release   = rd_issue && (rcol == LAST_COL);
    assign frame_done   = (state == ST_DRAIN) && (rrow == FRAME_ROWS);

    generate
        for (genvar b = 0; b < NUM_BUFS; b++) begin : g_buf
            kernel_line_buffer #(
                .DEPTH      (LINE_LENGTH),
                .DATA_WIDTH (DATA_WIDTH)
            ) u_buf (
                .clk     (i_clk),
                .wr_en   (wr_fire && (wsel == BUF_IDX_W'(b))),
                .wr_addr (wcol),
                .wr_data (i_data),
                .rd_addr (rcol),
                .rd_data (buf_rd[b])
            );
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (i_rstn) begin
            active <= 1'b0;
            wcol   <= '0;
            wsel   <= '0;
            wline  <= '0;
            filled <= '0;
        end else begin
            active <= 1'b1;
            if (wr_fire) begin
                if (wr_line_done) begin
                    wcol  <= '0;
                    wsel  <= wsel + BUF_IDX_W'(1);
                    wline <= wline + LINE_W'(1);
                end else begin
                    wcol <= wcol + COL_W'(1);
                end
            end
            // The two lines beyond the last output row are dropped at frame end.
            if (frame_done) begin
                filled <= '0;
                wsel   <= '0;
                wline  <= '0;
            end else begin
                filled <= filled + {2'b00, wr_line_done} - {2'b00, rd_release};
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rstn) begin
            state <= ST_IDLE;
            rcol  <= '0;
            rsel  <= '0;
            rrow  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (filled >= 3'd3) begin
                        state <= ST_LOAD;
                        rcol  <= '0;
                    end
                end
                ST_LOAD: begin
                    if (rcol == LAST_COL) begin
                        rcol  <= '0;
                        rsel  <= rsel + BUF_IDX_W'(1);
                        rrow  <= rrow + LINE_W'(1);
                        state <= ST_DRAIN;
                    end else begin
                        rcol <= rcol + COL_W'(1);
                    end
                end
                ST_DRAIN: begin
                    state <= ST_IDLE;
                    if (frame_done) begin
                        rsel <= '0;
                        rrow <= '0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // pend_sel remembers which buffer was oldest when the column was issued.
    always_comb begin
        px_top = buf_rd[pend_sel];
        px_mid = buf_rd[pend_sel + BUF_IDX_W'(1)];
        px_bot = buf_rd[pend_sel + BUF_IDX_W'(2)];
    end

    always_ff @(posedge i_clk) begin
        if (i_rstn) begin
            pend_valid <= 1'b0;
            pend_first <= 1'b0;
            pend_sel   <= '0;
            shift_cnt  <= '0;
            win_valid  <= 1'b0;
            win0       <= '0;
            win1       <= '0;
            win2       <= '0;
            o_valid    <= 1'b0;
            o_r0_data  <= '0;
            o_r1_data  <= '0;
            o_r2_data  <= '0;
        end else begin
            pend_valid <= rd_issue;
            pend_first <= rd_issue && (rcol == '0);
            pend_sel   <= rsel;
            win_valid  <= 1'b0;
            if (pend_valid) begin
                win0[F0 +: DATA_WIDTH] <= win0[F1 +: DATA_WIDTH];
                win0[F1 +: DATA_WIDTH] <= win0[F2 +: DATA_WIDTH];
                win0[F2 +: DATA_WIDTH] <= px_top;
                win1[F0 +: DATA_WIDTH] <= win1[F1 +: DATA_WIDTH];
                win1[F1 +: DATA_WIDTH] <= win1[F2 +: DATA_WIDTH];
                win1[F2 +: DATA_WIDTH] <= px_mid;
                win2[F0 +: DATA_WIDTH] <= win2[F1 +: DATA_WIDTH];
                win2[F1 +: DATA_WIDTH] <= win2[F2 +: DATA_WIDTH];
                win2[F2 +: DATA_WIDTH] <= px_bot;
                if (pend_first) begin
                    shift_cnt <= 2'd1;
                end else begin
                    if (shift_cnt != 2'd3) begin
                        shift_cnt <= shift_cnt + 2'd1;
                    end
                    win_valid <= (shift_cnt >= 2'd2);
                end
            end
            o_valid <= win_valid;
            if (win_valid) begin
                o_r0_data <= win0;
                o_r1_data <= win1;
                o_r2_data <= win2;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_kernel_control.sv
`default_nettype none
// ============================================================================
// tb_kernel_control : scoreboard bench for the kernel_control window generator
// Revision          : 1.0
// ============================================================================
module tb_kernel_control;

    localparam int LL        = 48;
    localparam int LC        = 48;
    localparam int DW        = 16;
    localparam int FRAME_PIX = LL * LC;

    logic            clk = 1'b0;
    logic            rstn;
    logic [DW-1:0]   data;
    logic            valid;
    logic            req;
    logic [3*DW-1:0] r0;
    logic [3*DW-1:0] r1;
    logic [3*DW-1:0] r2;
    logic            ovalid;

    kernel_control #(
        .LINE_LENGTH (LL),
        .LINE_COUNT  (LC),
        .DATA_WIDTH  (DW)
    ) dut (
        .i_clk     (clk),
        .i_rstn    (rstn),
        .i_data    (data),
        .i_valid   (valid),
        .o_req     (req),
        .o_r0_data (r0),
        .o_r1_data (r1),
        .o_r2_data (r2),
        .o_valid   (ovalid)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3*DW-1:0] r0;
        logic [3*DW-1:0] r1;
        logic [3*DW-1:0] r2;
    } win_t;

    win_t            exp_q[$];
    int              n_cmp = 0;
    int              n_err = 0;
    int              next_idx = 0;
    int              total_acc = 0;
    int              first_stall = -1;
    logic [DW-1:0]   frame_base = '0;
    int              run_len = 0;
    int              rows_done = 0;
    int              win_count = 0;
    logic [3*DW-1:0] run_first_r0, run_first_r1, run_first_r2, run_last_r0;

    function automatic logic [DW-1:0] pix(input logic [DW-1:0] base, input int l, input int c);
        return base + DW'(l * LL + c);
    endfunction

    function automatic logic [3*DW-1:0] slice(input logic [DW-1:0] base, input int l, input int c);
        return {pix(base, l, c + 2), pix(base, l, c + 1), pix(base, l, c)};
    endfunction

    // Scoreboard: each window becomes known when its bottom-right pixel is accepted.
    task automatic accept();
        int   l = next_idx / LL;
        int   c = next_idx % LL;
        win_t w;
        if (l >= 2 && c >= 2) begin
            w.r0 = slice(frame_base, l - 2, c - 2);
            w.r1 = slice(frame_base, l - 1, c - 2);
            w.r2 = slice(frame_base, l,     c - 2);
            exp_q.push_back(w);
        end
        next_idx++;
        total_acc++;
        if (next_idx == FRAME_PIX) begin
            next_idx   = 0;
            frame_base = frame_base + 16'h1000;
        end
    endtask

    task automatic clear_model();
        exp_q.delete();
        next_idx    = 0;
        total_acc   = 0;
        frame_base  = '0;
        first_stall = -1;
        rows_done   = 0;
        win_count   = 0;
    endtask

    task automatic stream(input int n, input bit garbage);
        int acc = 0;
        int cyc = 0;
        while (acc < n) begin
            @(negedge clk);
            cyc++;
            if (cyc > 8 * n + 500) begin
                n_cmp++;
                n_err++;
                $display("FAIL stream_timeout: accepted %0d, required %0d", acc, n);
                valid = 1'b0;
                return;
            end
            valid = 1'b1;
            if (req) begin
                data = pix(frame_base, 0, next_idx);
                accept();
                acc++;
            end else begin
                if (first_stall < 0) first_stall = total_acc;
                data = garbage ? 16'hBEEF : pix(frame_base, 0, next_idx);
            end
        end
    endtask

    task automatic idle_wait(input int cycles);
        @(negedge clk);
        valid = 1'b0;
        for (int i = 0; i < cycles && exp_q.size() != 0; i++) @(negedge clk);
        repeat (6) @(negedge clk);
    endtask

    task automatic do_reset();
        valid = 1'b0;
        rstn  = 1'b1;
        repeat (3) @(negedge clk);
        clear_model();
        rstn = 1'b0;
        @(negedge clk);
    endtask

    always @(negedge clk) begin : monitor
        win_t e;
        if (rstn) begin
            run_len = 0;
        end else if (ovalid) begin
            if (run_len == 0) begin
                run_first_r0 = r0;
                run_first_r1 = r1;
                run_first_r2 = r2;
            end
            run_last_r0 = r0;
            run_len++;
            win_count++;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL window_unexpected: got r0=%h r1=%h r2=%h, required no window", r0, r1, r2);
            end else begin
                e = exp_q.pop_front();
                if ({r0, r1, r2} !== e) begin
                    n_err++;
                    $display("FAIL window_value: got r0=%h r1=%h r2=%h, required r0=%h r1=%h r2=%h",
                             r0, r1, r2, e.r0, e.r1, e.r2);
                end
            end
        end else if (run_len != 0) begin
            n_cmp++;
            if (run_len != LL - 2) begin
                n_err++;
                $display("FAIL row_burst_len: got %0d, required %0d", run_len, LL - 2);
            end
            rows_done++;
            run_len = 0;
        end
    end

    task automatic test_reset();
        rstn  = 1'b1;
        valid = 1'b1;
        data  = 16'hAAAA;
        repeat (25) @(negedge clk);
        n_cmp += 5;
        if (req !== 1'b0)    begin n_err++; $display("FAIL reset_req: got %b, required 0", req); end
        if (ovalid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b, required 0", ovalid); end
        if (r0 !== '0)       begin n_err++; $display("FAIL reset_r0: got %h, required 0", r0); end
        if (r1 !== '0)       begin n_err++; $display("FAIL reset_r1: got %h, required 0", r1); end
        if (r2 !== '0)       begin n_err++; $display("FAIL reset_r2: got %h, required 0", r2); end
        valid = 1'b0;
        clear_model();
        rstn = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (req !== 1'b1) begin n_err++; $display("FAIL release_req: got %b, required 1", req); end
    endtask

    task automatic test_first_window();
        stream(143, 1'b0);
        idle_wait(10);
        n_cmp++;
        if (win_count != 0) begin n_err++; $display("FAIL early_window: got %0d windows, required 0", win_count); end
        stream(1, 1'b0);
        idle_wait(200);
        n_cmp += 5;
        if (rows_done != 1) begin n_err++; $display("FAIL first_rows: got %0d, required 1", rows_done); end
        if (run_first_r0 !== {16'd2, 16'd1, 16'd0})
            begin n_err++; $display("FAIL first_r0: got %h, required 000200010000", run_first_r0); end
        if (run_first_r1 !== {16'd50, 16'd49, 16'd48})
            begin n_err++; $display("FAIL first_r1: got %h, required 003200310030", run_first_r1); end
        if (run_first_r2 !== {16'd98, 16'd97, 16'd96})
            begin n_err++; $display("FAIL first_r2: got %h, required 006200610060", run_first_r2); end
        if (run_last_r0 !== {16'd47, 16'd46, 16'd45})
            begin n_err++; $display("FAIL last_r0: got %h, required 002f002e002d", run_last_r0); end
    endtask

    task automatic test_second_row();
        stream(48, 1'b0);
        idle_wait(200);
        n_cmp += 4;
        if (rows_done != 2) begin n_err++; $display("FAIL second_rows: got %0d, required 2", rows_done); end
        if (exp_q.size() != 0) begin n_err++; $display("FAIL second_drain: got %0d pending, required 0", exp_q.size()); end
        if (run_first_r0 !== {16'd50, 16'd49, 16'd48})
            begin n_err++; $display("FAIL second_r0: got %h, required 003200310030", run_first_r0); end
        if (run_first_r2 !== {16'd146, 16'd145, 16'd144})
            begin n_err++; $display("FAIL second_r2: got %h, required 009200910090", run_first_r2); end
    endtask

    task automatic test_backpressure();
        do_reset();
        stream(240, 1'b1);
        n_cmp++;
        if (first_stall != 192) begin n_err++; $display("FAIL first_stall: got %0d, required 192", first_stall); end
    endtask

    task automatic test_frame_end();
        int cyc = 0;
        stream(FRAME_PIX - 240, 1'b1);
        @(negedge clk);
        valid = 1'b0;
        n_cmp++;
        if (req !== 1'b0) begin n_err++; $display("FAIL frame_end_req: got %b, required 0", req); end
        while (!req && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        n_cmp++;
        if (!req) begin n_err++; $display("FAIL frame_clear_timeout: req got %b, required 1", req); end
        idle_wait(100);
        n_cmp += 3;
        if (rows_done != LC - 2) begin n_err++; $display("FAIL frame_rows: got %0d, required %0d", rows_done, LC - 2); end
        if (win_count != (LC - 2) * (LL - 2))
            begin n_err++; $display("FAIL frame_windows: got %0d, required %0d", win_count, (LC - 2) * (LL - 2)); end
        if (exp_q.size() != 0) begin n_err++; $display("FAIL frame_drain: got %0d pending, required 0", exp_q.size()); end
        stream(144, 1'b0);
        idle_wait(200);
        n_cmp += 2;
        if (rows_done != LC - 1) begin n_err++; $display("FAIL next_frame_rows: got %0d, required %0d", rows_done, LC - 1); end
        if (run_first_r0 !== {16'h1002, 16'h1001, 16'h1000})
            begin n_err++; $display("FAIL next_frame_r0: got %h, required 100210011000", run_first_r0); end
    endtask

    task automatic test_reset_mid_frame();
        int cyc = 0;
        do_reset();
        stream(150, 1'b0);
        @(negedge clk);
        valid = 1'b0;
        while (!ovalid && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        n_cmp++;
        if (!ovalid) begin n_err++; $display("FAIL mid_burst_timeout: valid got %b, required 1", ovalid); end
        rstn = 1'b1;
        exp_q.delete();
        @(negedge clk);
        n_cmp += 3;
        if (ovalid !== 1'b0) begin n_err++; $display("FAIL mid_reset_valid: got %b, required 0", ovalid); end
        if (r0 !== '0)       begin n_err++; $display("FAIL mid_reset_r0: got %h, required 0", r0); end
        if (req !== 1'b0)    begin n_err++; $display("FAIL mid_reset_req: got %b, required 0", req); end
        repeat (2) @(negedge clk);
        clear_model();
        rstn = 1'b0;
        @(negedge clk);
        stream(144, 1'b0);
        idle_wait(200);
        n_cmp += 3;
        if (rows_done != 1) begin n_err++; $display("FAIL restart_rows: got %0d, required 1", rows_done); end
        if (run_first_r0 !== {16'd2, 16'd1, 16'd0})
            begin n_err++; $display("FAIL restart_r0: got %h, required 000200010000", run_first_r0); end
        if (run_first_r2 !== {16'd98, 16'd97, 16'd96})
            begin n_err++; $display("FAIL restart_r2: got %h, required 006200610060", run_first_r2); end
    endtask

    initial begin
        rstn  = 1'b1;
        valid = 1'b0;
        data  = '0;
        test_reset();
        test_first_window();
        test_second_row();
        test_backpressure();
        test_frame_end();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation still running at time limit, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
